// File: rtl/online_cmd_rx_if.sv
// Command-side bundle of the online UART receiver: level, colour pulses, errors, last command.
interface online_cmd_rx_if;
  logic       online;
  logic       red;
  logic       green;
  logic       yellow;
  logic       cmd_err;
  logic       frame_err;
  logic [7:0] last_cmd;

  modport master (output online, red, green, yellow, cmd_err, frame_err, last_cmd);
  modport slave  (input  online, red, green, yellow, cmd_err, frame_err, last_cmd);
endinterface

// File: rtl/online_cmd_rx.sv
// 8N1 UART receiver feeding a command decoder for the host-controlled traffic-light mode.
// Emits the online level, single-cycle colour/error pulses and the last accepted command.
module online_cmd_rx #(
  parameter int BAUD_DIV   = 5208,
  parameter int SYNC_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  online_cmd_rx_if.master  cmd
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
  endfunction

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  rxd_s;
  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sh_q, sh_d;
  logic                  vld_p0, ferr_p0;
  logic [7:0]            byte_p0;
  logic [7:0]            ucmd_p0;

  logic                  online_p1, red_p1, green_p1, yellow_p1, cmd_err_p1, frame_err_p1;
  logic [7:0]            last_cmd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_DEPTH-2:0], rxd};
  end
  assign rxd_s = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) sh_q <= sh_d;

  // Sampling points: mid start bit, then every full bit period so data/stop land mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_p0  = 1'b0;
    ferr_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rxd_s) begin
            vld_p0  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_p0 = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_p0 = sh_q;
  assign ucmd_p0 = to_upper(byte_p0);

  // Decode stage: results are registered, one cycle after the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      online_p1    <= 1'b0;
      red_p1       <= 1'b0;
      green_p1     <= 1'b0;
      yellow_p1    <= 1'b0;
      cmd_err_p1   <= 1'b0;
      frame_err_p1 <= 1'b0;
      last_cmd_p1  <= 8'h00;
    end else begin
      red_p1       <= 1'b0;
      green_p1     <= 1'b0;
      yellow_p1    <= 1'b0;
      cmd_err_p1   <= 1'b0;
      frame_err_p1 <= ferr_p0;
      if (vld_p0) begin
        case (ucmd_p0)
          8'h4E: begin online_p1 <= 1'b1; last_cmd_p1 <= ucmd_p0; end
          8'h46: begin online_p1 <= 1'b0; last_cmd_p1 <= ucmd_p0; end
          8'h52: if (online_p1) begin red_p1    <= 1'b1; last_cmd_p1 <= ucmd_p0; end
          8'h47: if (online_p1) begin green_p1  <= 1'b1; last_cmd_p1 <= ucmd_p0; end
          8'h59: if (online_p1) begin yellow_p1 <= 1'b1; last_cmd_p1 <= ucmd_p0; end
          default: cmd_err_p1 <= 1'b1;
        endcase
      end
    end
  end

  assign cmd.online    = online_p1;
  assign cmd.red       = red_p1;
  assign cmd.green     = green_p1;
  assign cmd.yellow    = yellow_p1;
  assign cmd.cmd_err   = cmd_err_p1;
  assign cmd.frame_err = frame_err_p1;
  assign cmd.last_cmd  = last_cmd_p1;

endmodule

// File: tb/tb_online_cmd_rx.sv
// Randomized scoreboard bench for online_cmd_rx: a byte-level command model predicts
// every visible output event; a monitor pops and compares whenever the outputs change.
module tb_online_cmd_rx;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;

  online_cmd_rx_if bus ();

  online_cmd_rx #(.BAUD_DIV(BD), .SYNC_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .cmd   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r, g, y, ce, fe, on;
    logic [7:0] last;
  } ev_t;

  ev_t  expq[$];
  int   vectors = 0;
  int   errors  = 0;
  logic m_online = 1'b0;
  logic [7:0] m_last = 8'h00;

  // Reference: apply one received byte to the command model and queue any visible change.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] u;
    ev_t e;
    u = b;
    if (b >= 8'h61 && b <= 8'h7A) u = b - 8'h20;
    e = '0;
    if (u == "N") begin m_online = 1'b1; m_last = u; end
    else if (u == "F") begin m_online = 1'b0; m_last = u; end
    else if (u == "R" || u == "G" || u == "Y") begin
      if (m_online) begin
        m_last = u;
        e.r = (u == "R"); e.g = (u == "G"); e.y = (u == "Y");
      end
    end else e.ce = 1'b1;
    e.on = m_online;
    e.last = m_last;
    if (e.r || e.g || e.y || e.ce || e.on != prev_m_on || e.last != prev_m_last) expq.push_back(e);
    prev_m_on = m_online;
    prev_m_last = m_last;
  endtask

  logic prev_m_on = 1'b0;
  logic [7:0] prev_m_last = 8'h00;

  task automatic model_frame_err();
    ev_t e;
    e = '0;
    e.fe = 1'b1;
    e.on = m_online;
    e.last = m_last;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    m_online = 1'b0; m_last = 8'h00;
    prev_m_on = 1'b0; prev_m_last = 8'h00;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0; wait_cyc(BD);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; wait_cyc(BD); end
    rxd = stop_bit; wait_cyc(BD);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b);
    send_frame(b, 1'b1);
    wait_cyc(gap);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_online"}, 32'(bus.online), 32'd0);
    check({tag, "_red"}, 32'(bus.red), 32'd0);
    check({tag, "_green"}, 32'(bus.green), 32'd0);
    check({tag, "_yellow"}, 32'(bus.yellow), 32'd0);
    check({tag, "_cmd_err"}, 32'(bus.cmd_err), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_last_cmd"}, 32'(bus.last_cmd), 32'd0);
  endtask

  // Monitor: any pulse or any change of online/last_cmd is one output event.
  initial begin
    ev_t act, exp_e;
    logic p_on;
    logic [7:0] p_last;
    p_on = 1'b0; p_last = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_on = 1'b0; p_last = 8'h00;
      end else begin
        act = {bus.red, bus.green, bus.yellow, bus.cmd_err, bus.frame_err, bus.online, bus.last_cmd};
        if (act.r || act.g || act.y || act.ce || act.fe || act.on != p_on || act.last != p_last) begin
          vectors++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got r%b g%b y%b ce%b fe%b on%b last=%02h, none expected",
                     act.r, act.g, act.y, act.ce, act.fe, act.on, act.last);
          end else begin
            exp_e = expq.pop_front();
            if (act !== exp_e) begin
              errors++;
              $display("FAIL event: got r%b g%b y%b ce%b fe%b on%b last=%02h expected r%b g%b y%b ce%b fe%b on%b last=%02h",
                       act.r, act.g, act.y, act.ce, act.fe, act.on, act.last,
                       exp_e.r, exp_e.g, exp_e.y, exp_e.ce, exp_e.fe, exp_e.on, exp_e.last);
            end
          end
        end
        p_on = act.on; p_last = act.last;
      end
    end
  end

  initial begin
    logic [7:0] pool [10];
    logic [7:0] b;
    pool = '{8'h4E, 8'h46, 8'h52, 8'h47, 8'h59, 8'h6E, 8'h66, 8'h72, 8'h67, 8'h79};

    wait_cyc(4);
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    // Directed sequence: offline colour ignored, then online colours, bad byte, offline.
    send_byte("R", 5);
    send_byte("N", 0);
    send_byte("R", 5);
    send_byte("g", 0);
    send_byte("Y", 5);
    send_byte(8'h41, 5);
    send_byte("F", 5);

    // Short low glitch must not start a frame.
    rxd = 1'b0; wait_cyc(4); rxd = 1'b1;
    wait_cyc(3 * BD);

    // Stop bit low followed by a stuck-low line: a single frame error.
    model_frame_err();
    send_frame(8'h4E, 1'b0);
    rxd = 1'b0; wait_cyc(100); rxd = 1'b1;
    wait_cyc(2 * BD);
    send_byte("N", 2 * BD);

    // Reset in the middle of data bit 4 discards the partial byte.
    rxd = 1'b0; wait_cyc(BD);
    b = 8'h4E;
    for (int i = 0; i < 4; i++) begin rxd = b[i]; wait_cyc(BD); end
    rxd = b[4]; wait_cyc(BD / 2);
    rst_n = 1'b0;
    model_reset();
    wait_cyc(3);
    rxd = 1'b1;
    check_reset_state("midreset");
    rst_n = 1'b1;
    wait_cyc(2 * BD);
    send_byte("N", 5);

    // Randomized traffic: command letters of both cases plus arbitrary bytes.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 9)];
      send_byte(b, $urandom_range(0, 20));
    end

    wait_cyc(20 * BD);
    check("queue_drained", 32'(expq.size()), 32'd0);
    check("final_online", 32'(bus.online), 32'(m_online));
    check("final_last_cmd", 32'(bus.last_cmd), 32'(m_last));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
